// File: rtl/led_pattern_engine.sv
// Multi-channel LED driver: a shared prescaler produces a slow tick, and each channel
// independently shows off, on, blink or PWM, reconfigured through a single-cycle write port.
module led_pattern_engine #(
  parameter int CLK_HZ   = 48_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int N_CH     = 3,
  parameter int PERIOD_W = 12,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_duty,
  output logic                tick,
  output logic [N_CH-1:0]     led
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [CNT_W-1:0] prescale;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (prescale == CNT_LAST);
      prescale <= (prescale == CNT_LAST) ? '0 : prescale + CNT_W'(1);
    end
  end

  mode_t               mode_q   [N_CH];
  logic [PERIOD_W-1:0] period_q [N_CH];
  logic [PERIOD_W-1:0] duty_q   [N_CH];
  logic [PERIOD_W-1:0] phase_q  [N_CH];
  logic [N_CH-1:0]     blink_q;

  mode_t               mode_d   [N_CH];
  logic [PERIOD_W-1:0] period_d [N_CH];
  logic [PERIOD_W-1:0] duty_d   [N_CH];
  logic [PERIOD_W-1:0] phase_d  [N_CH];
  logic [PERIOD_W-1:0] eff_period [N_CH];
  logic [N_CH-1:0]     blink_d;
  logic [N_CH-1:0]     wr_sel;
  logic [N_CH-1:0]     led_d;
  logic                write_hit;

  assign write_hit = cfg_we && ({1'b0, cfg_ch} < N_CH_L);

  // A stored period of zero behaves as one tick.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      eff_period[i] = (period_q[i] == '0) ? PERIOD_W'(1) : period_q[i];
      wr_sel[i]     = write_hit && (cfg_ch == CH_W'(i));
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    blink_d = blink_q;
    led_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      phase_d[i]  = phase_q[i];

      // A write to this channel wins over a coincident tick.
      if (wr_sel[i]) begin
        mode_d[i]   = mode_t'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        phase_d[i]  = '0;
        blink_d[i]  = 1'b1;
      end else if (tick) begin
        if (phase_q[i] == eff_period[i] - PERIOD_W'(1)) begin
          phase_d[i] = '0;
          blink_d[i] = ~blink_q[i];
        end else begin
          phase_d[i] = phase_q[i] + PERIOD_W'(1);
        end
      end

      case (mode_d[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_d[i];
        MODE_PWM:   led_d[i] = (phase_d[i] < duty_d[i]);
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  // NOTE: the per-channel arrays are plain registers, so they are reset like any other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= PERIOD_W'(1);
        duty_q[i]   <= '0;
        phase_q[i]  <= '0;
      end
      blink_q <= '1;
      led     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        phase_q[i]  <= phase_d[i];
      end
      blink_q <= blink_d;
      led     <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with DIV=10; cyc counts posedges since reset release,
// so tick is visible on samples where cyc is a multiple of 10 and channels advance on those edges.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_period;
  logic [3:0] cfg_duty;
  logic       tick;
  logic [2:0] led;

  int cyc;
  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .CLK_HZ  (100),
    .TICK_HZ (10),
    .N_CH    (3),
    .PERIOD_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .tick      (tick),
    .led       (led)
  );

  task automatic cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) cycle();
  endtask

  // Presents a write for exactly one posedge; returns on the sample after that edge.
  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [3:0] per, input logic [3:0] duty);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = duty;
    cycle();
    cfg_we     = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    reset = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    n_vec++;
    if (led !== 3'b000 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: led=%b tick=%b, want led=000 tick=0", led, tick);
    end
    for (int k = 0; k < 30; k++) begin
      cycle();
      exp_tick = (cyc % 10 == 0);
      n_vec++;
      if (tick !== exp_tick || led !== 3'b000) begin
        n_err++;
        $display("FAIL reset_tick cyc=%0d: tick=%b led=%b, want tick=%b led=000",
                 cyc, tick, led, exp_tick);
      end
    end
  endtask

  // ch0 blink period 3 written at edge 32: ticks at 40,50,60 -> dark from 61, lit again from 91, ...
  task automatic test_blink();
    logic exp;
    run_to(32);
    write_cfg(2'd0, 2'b10, 4'd3, 4'd0);
    while (cyc <= 150) begin
      exp = (cyc <= 60) || (cyc >= 91 && cyc <= 120);
      n_vec++;
      if (led[0] !== exp || led[2:1] !== 2'b00) begin
        n_err++;
        $display("FAIL blink cyc=%0d: led=%b, want led[0]=%b led[2:1]=00", cyc, led, exp);
      end
      cycle();
    end
  endtask

  // ch1 pwm period 4 duty 1 written at edge 152: phase 0 during 153..160, 191..200, 231..240.
  task automatic test_pwm();
    logic exp;
    run_to(152);
    write_cfg(2'd1, 2'b11, 4'd4, 4'd1);
    while (cyc <= 240) begin
      exp = (cyc <= 160) || (cyc >= 191 && cyc <= 200) || (cyc >= 231);
      n_vec++;
      if (led[1] !== exp || led[2] !== 1'b0) begin
        n_err++;
        $display("FAIL pwm_duty1 cyc=%0d: led=%b, want led[1]=%b led[2]=0", cyc, led, exp);
      end
      cycle();
    end
    run_to(242);
    write_cfg(2'd1, 2'b11, 4'd4, 4'd5);
    while (cyc <= 290) begin
      n_vec++;
      if (led[1] !== 1'b1) begin
        n_err++;
        $display("FAIL pwm_duty5 cyc=%0d: led[1]=%b, want 1", cyc, led[1]);
      end
      cycle();
    end
    run_to(292);
    write_cfg(2'd1, 2'b11, 4'd4, 4'd0);
    while (cyc <= 330) begin
      n_vec++;
      if (led[1] !== 1'b0) begin
        n_err++;
        $display("FAIL pwm_duty0 cyc=%0d: led[1]=%b, want 0", cyc, led[1]);
      end
      cycle();
    end
  endtask

  // ch2 blink with period 0 toggles on every tick; then a write to channel 3 must be ignored.
  task automatic test_edge_config();
    logic       exp;
    logic [2:0] exp_v;
    run_to(332);
    write_cfg(2'd2, 2'b10, 4'd0, 4'd0);
    while (cyc <= 370) begin
      exp = (cyc <= 340) || (cyc >= 351 && cyc <= 360);
      n_vec++;
      if (led[2] !== exp) begin
        n_err++;
        $display("FAIL period0 cyc=%0d: led[2]=%b, want %b", cyc, led[2], exp);
      end
      cycle();
    end
    run_to(372);
    write_cfg(2'd3, 2'b01, 4'd5, 4'd5);
    while (cyc <= 400) begin
      if (cyc <= 380)      exp_v = 3'b100;
      else if (cyc <= 390) exp_v = 3'b000;
      else                 exp_v = 3'b101;
      n_vec++;
      if (led !== exp_v) begin
        n_err++;
        $display("FAIL bad_channel cyc=%0d: led=%b, want %b", cyc, led, exp_v);
      end
      cycle();
    end
  endtask

  // ch1 pwm period 2 duty 1 from edge 402; ch0 rewritten as blink period 2 on tick edge 430.
  task automatic test_collision();
    logic       exp;
    logic [1:0] exp_v;
    run_to(402);
    write_cfg(2'd1, 2'b11, 4'd2, 4'd1);
    while (cyc < 430) begin
      exp = (cyc <= 410) || (cyc >= 421);
      n_vec++;
      if (led[1] !== exp) begin
        n_err++;
        $display("FAIL pre_collide cyc=%0d: led[1]=%b, want %b", cyc, led[1], exp);
      end
      cycle();
    end
    n_vec++;
    if (tick !== 1'b1 || led[1] !== 1'b1) begin
      n_err++;
      $display("FAIL collide_setup cyc=%0d: tick=%b led[1]=%b, want tick=1 led[1]=1",
               cyc, tick, led[1]);
    end
    write_cfg(2'd0, 2'b10, 4'd2, 4'd0);
    while (cyc <= 480) begin
      exp_v[0] = (cyc <= 450) || (cyc >= 471);
      exp_v[1] = (cyc >= 441 && cyc <= 450) || (cyc >= 461 && cyc <= 470);
      n_vec++;
      if (led[1:0] !== exp_v) begin
        n_err++;
        $display("FAIL collide cyc=%0d: led[1:0]=%b, want %b", cyc, led[1:0], exp_v);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic exp_tick;
    run_to(485);
    n_vec++;
    if (led !== 3'b011) begin
      n_err++;
      $display("FAIL pre_reset cyc=%0d: led=%b, want 011", cyc, led);
    end
    reset = 1'b1;
    cycle();
    n_vec++;
    if (led !== 3'b000 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: led=%b tick=%b, want led=000 tick=0", led, tick);
    end
    reset = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      cycle();
      exp_tick = (cyc % 10 == 0);
      n_vec++;
      if (tick !== exp_tick || led !== 3'b000) begin
        n_err++;
        $display("FAIL post_reset cyc=%0d: tick=%b led=%b, want tick=%b led=000",
                 cyc, tick, led, exp_tick);
      end
    end
    run_to(42);
    write_cfg(2'd0, 2'b01, 4'd0, 4'd0);
    n_vec++;
    if (led !== 3'b001) begin
      n_err++;
      $display("FAIL rewrite_after_reset: led=%b, want 001", led);
    end
  endtask

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_blink();
    test_pwm();
    test_edge_config();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
